deshuffle_unit: RTL and testbench
=================================

# deshuffle_unit

Store-path counterpart of the load shuffle stage in the VLSU. Collects one beat per lane from the lane entries, undoes the lane-interleaved element layout, and emits one sequential-order beat (nibble data + nibble enables) toward the StoreUnit. A small meta-info FIFO supplies the element width, request id and beat count for each store request.

## Interface
Parameters:
- NrLanes, 4: number of lanes; power of two, at least 2.
- DLEN, 64: bits per lane beat. NbPerLane = DLEN/4 nibbles per lane; NbTotal = NrLanes*NbPerLane.
- InfoDepth, 4: meta-info FIFO depth; power of two.
- IdBits, 4: width of the request id.
- CntBits, 8: width of the beat counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- meta_valid_i  in  1  meta-info valid.
- meta_ready_o  out  1  meta-info ready.
- meta_req_id_i  in  IdBits  request id.
- meta_eew_i  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- meta_cmt_cnt_i  in  CntBits  number of beats in the request minus 1.
- rx_valid_i  in  NrLanes  per-lane beat valid.
- rx_ready_o  out  NrLanes  per-lane beat ready.
- rx_data_i  in  NrLanes x DLEN  lane data; nibble `off` of lane `l` is bits [4*off+3:4*off].
- rx_nbe_i  in  NrLanes x NbPerLane  lane nibble enables, already masked by the lane.
- tx_valid_o  out  1  sequential beat valid.
- tx_ready_i  in  1  sequential beat ready.
- tx_nb_o  out  NbTotal x 4  sequential nibbles.
- tx_en_o  out  NbTotal  sequential nibble enables.
- tx_req_id_o  out  IdBits  request id of the beat.
- tx_last_o  out  1  final beat of the request.

## Operation
- Meta FIFO:
  - Enqueue and dequeue pointers each carry a wrap flag.
  - Empty when values are equal and flags are equal; full when values are equal and flags differ.
  - meta_ready_o = !full.
  - The head entry's cnt is decremented in place on each commit.
- Lane staging registers, one per lane (lane_valid, data, nbe):
  - rx_ready_o[l] = !lane_valid[l]. The ready is register-only, with no combinational path from any other input.
  - A handshake on lane l sets lane_valid[l] and captures data and nbe.
  - Lanes fill independently, in any order, including before any meta info exists.
- Commit condition: &lane_valid && !fifo_empty && (!tx_valid_o || tx_ready_i).
- Deshuffle, for each s in 0..NbTotal-1, with B2 = 2<<eew nibbles per element:
  - e = s / B2; k = s % B2.
  - lane = e % NrLanes; off = (e / NrLanes)*B2 + k.
  - tx_nb[s] = lane_data[lane][off].
  - tx_en[s] = lane_nbe[lane][off].
- On commit:
  - Load the output register with the deshuffled beat.
  - Set tx_req_id_o = head.req_id.
  - Set tx_last_o = (head.cnt == 0).
  - Clear all lane_valid bits.
  - If head.cnt == 0, dequeue the head entry; otherwise decrement head.cnt.
- Output register:
  - tx_valid_o is set on commit.
  - It is cleared on tx handshake unless a commit happens in the same cycle.
  - Contents are stable while tx_valid_o && !tx_ready_i.
- Simultaneous events:
  - Meta enqueue and dequeue in the same cycle are both applied.
  - A lane handshake cannot coincide with a commit clear of that lane, because its ready was low.

## Timing
- Reset values:
  - meta_ready_o=1, rx_ready_o=all 1, tx_valid_o=0.
  - tx_nb_o, tx_en_o, tx_req_id_o, tx_last_o all 0.
  - FIFO empty, all lane_valid=0.
- Latency:
  - Last lane handshake at edge t: lane_valid is visible in cycle t+1, commit occurs at edge t+1, tx_valid_o is high in cycle t+2.
  - Meta info enqueued at edge t is usable for a commit in cycle t+1.
- Throughput: at most one beat per 2 cycles, because lane ready is low for the cycle after capture.
- Backpressure:
  - With tx stalled and lanes full, no commit occurs.
  - All rx_ready_o stay 0 and the output beat is held.
- FIFO full: meta_ready_o=0. A dequeue in that cycle raises it in the next cycle only.
- Reset mid-request: all state is dropped immediately; partial beats are discarded.

## Test plan
- Reset: check all outputs against their reset values while rx_valid_i=1111 and meta_valid_i=1.
- eew=0, cnt=0:
  - Stimulus: lane l data nibble off = 16*l+off, all nbe=1.
  - Expect tx_nb[0..1] = 0,1; tx_nb[2..3] = 16,17; tx_nb[8] = 2; tx_last_o = 1 in cycle t+2.
  - FIFO is empty afterwards.
- eew=3, cnt=2:
  - Stimulus: three lane beats.
  - Expect tx_nb[0..15] = lane0 off 0..15 and tx_nb[16] = lane1 off 0.
  - tx_last_o = 0, 0, 1 across the three beats; the req_id is the same on all three.
- Staggered lanes and no meta info:
  - Stimulus: lanes arrive on cycles 0, 3, 5, 9; meta info arrives on cycle 12.
  - Expect no commit before meta arrives and tx_valid_o in cycle 14.
  - rx_ready_o of each filled lane stays 0 until then.
- Backpressure: hold tx_ready_i=0 for 5 cycles with the next lane beats presented; the output beat is stable and the beat sequence is preserved.
- FIFO full: enqueue 5 meta entries with InfoDepth=4; the 5th is held until the first request's last beat commits, and the pointer wrap is correct.

Source files
------------

// File: rtl/deshuffle_unit.sv
// Store-path deshuffle: gathers one beat per lane, undoes the lane-interleaved
// element layout and emits one sequential beat (nibbles + enables) per commit.
module deshuffle_unit #(
    parameter int unsigned NrLanes   = 4,
    parameter int unsigned DLEN      = 64,
    parameter int unsigned InfoDepth = 4,
    parameter int unsigned IdBits    = 4,
    parameter int unsigned CntBits   = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    // A transfer happens on every rising edge where valid and ready are both
    // high; a source holds valid and payload steady until that edge.
    input  logic                                  meta_valid_i,
    output logic                                  meta_ready_o,
    input  logic [IdBits-1:0]                     meta_req_id_i,
    input  logic [1:0]                            meta_eew_i,
    input  logic [CntBits-1:0]                    meta_cmt_cnt_i,
    input  logic [NrLanes-1:0]                    rx_valid_i,
    output logic [NrLanes-1:0]                    rx_ready_o,
    input  logic [NrLanes-1:0][DLEN-1:0]          rx_data_i,
    input  logic [NrLanes-1:0][DLEN/4-1:0]        rx_nbe_i,
    output logic                                  tx_valid_o,
    input  logic                                  tx_ready_i,
    output logic [NrLanes*DLEN/4-1:0][3:0]        tx_nb_o,
    output logic [NrLanes*DLEN/4-1:0]             tx_en_o,
    output logic [IdBits-1:0]                     tx_req_id_o,
    output logic                                  tx_last_o
);

    localparam int unsigned NbPerLane = DLEN / 4;
    localparam int unsigned NbTotal   = NrLanes * NbPerLane;
    localparam int unsigned PtrW      = $clog2(InfoDepth);
    localparam logic [PtrW:0]    PtrOne = (PtrW + 1)'(1);
    localparam logic [CntBits-1:0] CntOne = CntBits'(1);

    // Meta FIFO: pointers carry a wrap flag in their MSB.
    logic [PtrW:0]        r_wr_ptr;
    logic [PtrW:0]        r_rd_ptr;
    logic [IdBits-1:0]    r_meta_id  [InfoDepth];
    logic [1:0]           r_meta_eew [InfoDepth];
    logic [CntBits-1:0]   r_meta_cnt [InfoDepth];

    logic [PtrW-1:0]      w_wr_idx;
    logic [PtrW-1:0]      w_rd_idx;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_commit;
    logic                 w_head_last;
    logic [1:0]           w_head_eew;
    logic [IdBits-1:0]    w_head_id;

    assign w_wr_idx    = r_wr_ptr[PtrW-1:0];
    assign w_rd_idx    = r_rd_ptr[PtrW-1:0];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]);
    assign w_enq       = meta_valid_i && !w_full;
    assign w_head_last = (r_meta_cnt[w_rd_idx] == '0);
    assign w_head_eew  = r_meta_eew[w_rd_idx];
    assign w_head_id   = r_meta_id[w_rd_idx];
    assign w_deq       = w_commit && w_head_last;
    assign meta_ready_o = !w_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PtrOne;
            if (w_deq) r_rd_ptr <= r_rd_ptr + PtrOne;
        end
    end

    // Enqueue never targets the head slot while a commit can happen (FIFO
    // would have to be full), so the in-place decrement cannot collide.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_meta_id[w_wr_idx]  <= meta_req_id_i;
            r_meta_eew[w_wr_idx] <= meta_eew_i;
            r_meta_cnt[w_wr_idx] <= meta_cmt_cnt_i;
        end
        if (w_commit && !w_head_last) begin
            r_meta_cnt[w_rd_idx] <= r_meta_cnt[w_rd_idx] - CntOne;
        end
    end

    // Lane staging registers.
    logic [NrLanes-1:0]                 r_lane_valid;
    logic [NrLanes-1:0][DLEN-1:0]       r_lane_data;
    logic [NrLanes-1:0][NbPerLane-1:0]  r_lane_nbe;
    logic [NrLanes-1:0]                 w_lane_hs;

    assign rx_ready_o = ~r_lane_valid;
    assign w_lane_hs  = rx_valid_i & ~r_lane_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lane_valid <= '0;
        end else if (w_commit) begin
            r_lane_valid <= '0;
        end else begin
            r_lane_valid <= r_lane_valid | w_lane_hs;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NrLanes; l++) begin
            if (w_lane_hs[l]) begin
                r_lane_data[l] <= rx_data_i[l];
                r_lane_nbe[l]  <= rx_nbe_i[l];
            end
        end
    end

    // Fixed wiring per element width; the head entry's eew picks one.
    logic [3:0][NbTotal-1:0][3:0] w_nb_eew;
    logic [3:0][NbTotal-1:0]      w_en_eew;

    for (genvar g = 0; g < 4; g++) begin : g_eew
        for (genvar s = 0; s < NbTotal; s++) begin : g_nib
            localparam int unsigned B2   = 2 << g;
            localparam int unsigned Elem = s / B2;
            localparam int unsigned Lane = Elem % NrLanes;
            localparam int unsigned Off  = (Elem / NrLanes) * B2 + (s % B2);
            assign w_nb_eew[g][s] = r_lane_data[Lane][4*Off +: 4];
            assign w_en_eew[g][s] = r_lane_nbe[Lane][Off];
        end
    end

    logic                      r_tx_valid;
    logic [NbTotal-1:0][3:0]   r_tx_nb;
    logic [NbTotal-1:0]        r_tx_en;
    logic [IdBits-1:0]         r_tx_id;
    logic                      r_tx_last;

    assign w_commit = (&r_lane_valid) && !w_empty && (!r_tx_valid || tx_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_valid <= 1'b0;
            r_tx_nb    <= '0;
            r_tx_en    <= '0;
            r_tx_id    <= '0;
            r_tx_last  <= 1'b0;
        end else if (w_commit) begin
            r_tx_valid <= 1'b1;
            r_tx_nb    <= w_nb_eew[w_head_eew];
            r_tx_en    <= w_en_eew[w_head_eew];
            r_tx_id    <= w_head_id;
            r_tx_last  <= w_head_last;
        end else if (tx_ready_i) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_valid_o  = r_tx_valid;
    assign tx_nb_o     = r_tx_nb;
    assign tx_en_o     = r_tx_en;
    assign tx_req_id_o = r_tx_id;
    assign tx_last_o   = r_tx_last;

endmodule

// File: tb/tb_deshuffle_unit.sv
// Bench for deshuffle_unit: directed lane/meta traffic, a queue-based model of
// the sequential beats, and literal spot checks on nibble placement and timing.
module tb_deshuffle_unit;

    localparam int NL    = 4;
    localparam int DL    = 64;
    localparam int NBPL  = DL / 4;
    localparam int NBT   = NL * NBPL;
    localparam int IDB   = 4;
    localparam int CB    = 8;
    localparam int DEPTH = 4;
    localparam int W     = NBT * 4 + NBT + IDB + 1;

    typedef logic [NL-1:0][DL-1:0]   data_t;
    typedef logic [NL-1:0][NBPL-1:0] nbe_t;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   meta_valid_i = 1'b0;
    logic                   meta_ready_o;
    logic [IDB-1:0]         meta_req_id_i = '0;
    logic [1:0]             meta_eew_i = '0;
    logic [CB-1:0]          meta_cmt_cnt_i = '0;
    logic [NL-1:0]          rx_valid_i = '0;
    logic [NL-1:0]          rx_ready_o;
    data_t                  rx_data_i = '0;
    nbe_t                   rx_nbe_i = '0;
    logic                   tx_valid_o;
    logic                   tx_ready_i = 1'b1;
    logic [NBT-1:0][3:0]    tx_nb_o;
    logic [NBT-1:0]         tx_en_o;
    logic [IDB-1:0]         tx_req_id_o;
    logic                   tx_last_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]   exp_q[$];
    data_t          grp_d_q[$];
    nbe_t           grp_n_q[$];
    logic [IDB-1:0] m_id_q[$];
    logic [1:0]     m_eew_q[$];
    int             m_cnt_q[$];
    int             m_done = 0;

    always #5 clk_i = ~clk_i;

    deshuffle_unit #(
        .NrLanes(NL), .DLEN(DL), .InfoDepth(DEPTH), .IdBits(IDB), .CntBits(CB)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
        .meta_req_id_i(meta_req_id_i), .meta_eew_i(meta_eew_i),
        .meta_cmt_cnt_i(meta_cmt_cnt_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .rx_data_i(rx_data_i), .rx_nbe_i(rx_nbe_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_nb_o(tx_nb_o), .tx_en_o(tx_en_o),
        .tx_req_id_o(tx_req_id_o), .tx_last_o(tx_last_o)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Sequential beat from lane beats: element e lives in lane e%NL, slot e/NL.
    function automatic logic [W-1:0] model_beat(data_t d, nbe_t n, logic [1:0] eew,
                                                logic [IDB-1:0] id, logic last);
        logic [NBT-1:0][3:0] nb;
        logic [NBT-1:0]      en;
        int b2, e, lane, off;
        b2 = 2 << eew;
        for (int s = 0; s < NBT; s++) begin
            e    = s / b2;
            lane = e % NL;
            off  = (e / NL) * b2 + (s % b2);
            nb[s] = d[lane][4*off +: 4];
            en[s] = n[lane][off];
        end
        return {nb, en, id, last};
    endfunction

    function automatic void model_pair();
        logic last;
        while (grp_d_q.size() > 0 && m_id_q.size() > 0) begin
            last = (m_done == m_cnt_q[0]);
            exp_q.push_back(model_beat(grp_d_q.pop_front(), grp_n_q.pop_front(),
                                       m_eew_q[0], m_id_q[0], last));
            if (last) begin
                void'(m_id_q.pop_front());
                void'(m_eew_q.pop_front());
                void'(m_cnt_q.pop_front());
                m_done = 0;
            end else begin
                m_done++;
            end
        end
    endfunction

    function automatic data_t pat(int base);
        data_t d;
        for (int l = 0; l < NL; l++)
            for (int off = 0; off < NBPL; off++)
                d[l][4*off +: 4] = 4'((3*l + off + base) & 15);
        return d;
    endfunction

    function automatic nbe_t nbe_pat(int k);
        nbe_t n;
        for (int l = 0; l < NL; l++)
            n[l] = 16'hFFFF ^ (16'h1 << ((5*l + k) % 16)) ^ (16'h8000 >> l);
        return n;
    endfunction

    // Called at a negedge; ready is a register so it is stable here.
    task automatic send_meta(input logic [IDB-1:0] id, input logic [1:0] eew, input int cnt);
        int c = 0;
        bit done = 0;
        meta_valid_i = 1'b1;
        meta_req_id_i = id;
        meta_eew_i = eew;
        meta_cmt_cnt_i = CB'(cnt);
        while (!done && c < 300) begin
            if (meta_ready_o) begin
                done = 1;
                m_id_q.push_back(id);
                m_eew_q.push_back(eew);
                m_cnt_q.push_back(cnt);
                model_pair();
            end
            @(negedge clk_i);
            c++;
        end
        meta_valid_i = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL meta_timeout: id %0d not accepted within %0d cycles", id, c);
        end
    endtask

    task automatic send_group(input data_t d, input nbe_t n,
                              input int d0, input int d1, input int d2, input int d3);
        int dly[NL];
        logic [NL-1:0] pend;
        int c = 0;
        dly = '{d0, d1, d2, d3};
        pend = '1;
        grp_d_q.push_back(d);
        grp_n_q.push_back(n);
        model_pair();
        rx_data_i = d;
        rx_nbe_i = n;
        while (pend != '0 && c < 300) begin
            for (int l = 0; l < NL; l++) begin
                rx_valid_i[l] = pend[l] && (c >= dly[l]);
                if (rx_valid_i[l] && rx_ready_o[l]) pend[l] = 1'b0;
            end
            @(negedge clk_i);
            c++;
        end
        rx_valid_i = '0;
        if (pend != '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL lane_timeout: pending lanes %b after %0d cycles", pend, c);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() > 0 && c < 300) begin
            @(negedge clk_i);
            c++;
        end
        chk("drain_pending_beats", exp_q.size(), 0);
    endtask

    // Checks every presented beat against the model, including held beats.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_ni && tx_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got id %0d last %0d expected no beat",
                             tx_req_id_o, tx_last_o);
                end else begin
                    chk("tx_beat", {tx_nb_o, tx_en_o, tx_req_id_o, tx_last_o}, exp_q[0]);
                    if (tx_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inputs active
        rx_valid_i = '1;
        meta_valid_i = 1'b1;
        rx_data_i = pat(5);
        rx_nbe_i = '1;
        repeat (3) @(negedge clk_i);
        chk("rst_meta_ready", meta_ready_o, 1);
        chk("rst_rx_ready", rx_ready_o, 4'hF);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_tx_nb", tx_nb_o, 0);
        chk("rst_tx_en", tx_en_o, 0);
        chk("rst_tx_id", tx_req_id_o, 0);
        chk("rst_tx_last", tx_last_o, 0);
        rx_valid_i = '0;
        meta_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // eew=0, single beat
        send_meta(4'd3, 2'd0, 0);
        send_group(pat(0), '1, 0, 0, 0, 0);
        chk("e0_no_valid_t1", tx_valid_o, 0);
        @(negedge clk_i);
        chk("e0_valid_t2", tx_valid_o, 1);
        chk("e0_nb0", tx_nb_o[0], 0);
        chk("e0_nb1", tx_nb_o[1], 1);
        chk("e0_nb2", tx_nb_o[2], 3);
        chk("e0_nb3", tx_nb_o[3], 4);
        chk("e0_nb6", tx_nb_o[6], 9);
        chk("e0_nb8", tx_nb_o[8], 2);
        chk("e0_last", tx_last_o, 1);
        chk("e0_id", tx_req_id_o, 3);
        drain();

        // eew=3, three beats
        send_meta(4'd5, 2'd3, 2);
        for (int b = 0; b < 3; b++) begin
            send_group(pat(b + 1), '1, 0, 0, 0, 0);
            @(negedge clk_i);
            chk("e3_valid", tx_valid_o, 1);
            chk("e3_id", tx_req_id_o, 5);
            chk("e3_last", tx_last_o, (b == 2) ? 1 : 0);
            if (b == 0) begin
                chk("e3_nb0", tx_nb_o[0], 1);
                chk("e3_nb15", tx_nb_o[15], 0);
                chk("e3_nb16", tx_nb_o[16], 4);
                chk("e3_nb63", tx_nb_o[63], 9);
            end
        end
        drain();

        // eew=1 and eew=2 with patterned enables
        send_meta(4'd7, 2'd1, 0);
        send_meta(4'd8, 2'd2, 0);
        send_group(pat(4), nbe_pat(1), 0, 0, 0, 0);
        @(negedge clk_i);
        chk("e1_nb4", tx_nb_o[4], 7);
        send_group(pat(9), nbe_pat(6), 0, 0, 0, 0);
        drain();

        // Staggered lanes, meta arrives late
        fork
            send_group(pat(11), nbe_pat(3), 0, 3, 5, 9);
            begin
                repeat (12) @(negedge clk_i);
                chk("stag_lanes_held", rx_ready_o, 0);
                chk("stag_no_tx_early", tx_valid_o, 0);
                send_meta(4'd9, 2'd2, 0);
                chk("stag_no_tx_t1", tx_valid_o, 0);
                @(negedge clk_i);
                chk("stag_tx_t2", tx_valid_o, 1);
            end
        join
        drain();

        // Backpressure with the next beat staged
        tx_ready_i = 1'b0;
        send_meta(4'd6, 2'd1, 1);
        send_group(pat(2), nbe_pat(2), 0, 0, 0, 0);
        send_group(pat(7), nbe_pat(8), 0, 1, 0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_rx_ready", rx_ready_o, 0);
            chk("bp_tx_valid", tx_valid_o, 1);
            chk("bp_tx_last", tx_last_o, 0);
        end
        tx_ready_i = 1'b1;
        drain();

        // FIFO full and pointer wrap
        send_meta(4'd1, 2'd0, 1);
        send_meta(4'd2, 2'd1, 0);
        send_meta(4'd3, 2'd2, 0);
        send_meta(4'd4, 2'd3, 0);
        chk("full_ready_low", meta_ready_o, 0);
        send_group(pat(12), '1, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("full_after_first_beat", meta_ready_o, 0);
        send_group(pat(13), nbe_pat(4), 0, 0, 0, 0);
        chk("full_at_last_commit", meta_ready_o, 0);
        @(negedge clk_i);
        chk("full_ready_after_deq", meta_ready_o, 1);
        send_meta(4'd10, 2'd0, 0);
        send_group(pat(14), nbe_pat(5), 0, 0, 0, 0);
        send_group(pat(15), nbe_pat(9), 0, 0, 0, 0);
        send_group(pat(3), nbe_pat(10), 0, 0, 0, 0);
        send_group(pat(6), nbe_pat(11), 0, 0, 0, 0);
        drain();
        chk("meta_model_empty", m_id_q.size(), 0);

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
